// File: rtl/hit_resolver_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hit_resolver_pkg
//  Description : Shared game encodings for the hit resolver. Holds the
//                stunmode codes from hit detection, the winner codes, and
//                the health/timer widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package hit_resolver_pkg;

    localparam int HEALTH_W = 3;
    localparam int TIMER_W  = 6;

    // Stunmode codes driven by combinational hit detection
    localparam logic [1:0] STUN_NEUTRAL = 2'b00;
    localparam logic [1:0] STUN_HIT     = 2'b01;
    localparam logic [1:0] STUN_BLOCK   = 2'b10;
    localparam logic [1:0] STUN_WHIFF   = 2'b11;

    // Winner codes; bit 1 = P1 was knocked out, bit 0 = P2 was knocked out
    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    // Decrement that sticks at zero
    function automatic logic [HEALTH_W-1:0] health_sat_dec(
        input logic [HEALTH_W-1:0] value
    );
        return (value == '0) ? value : value - HEALTH_W'(1);
    endfunction

    function automatic logic [TIMER_W-1:0] timer_sat_dec(
        input logic [TIMER_W-1:0] value
    );
        return (value == '0) ? value : value - TIMER_W'(1);
    endfunction

endpackage : hit_resolver_pkg
`default_nettype wire

// File: rtl/stun_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : stun_tracker
//  Description : Per-player hit bookkeeping. Edge-detects new hits/blocks on
//                the stunmode code, keeps the health counter and the
//                hitstun/blockstun frame timers.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                clear_i           - round restart (same effect as rst)
//                tick_i            - frame tick (already masked by clear_i)
//                frozen_i          - game over: ignore events, freeze health
//                stunmode_i        - 2-bit stunmode code from hit detection
//                health_o          - registered health
//                hitstun_o         - hitstun timer nonzero
//                blockstun_o       - blockstun timer nonzero
//                ko_o              - health becomes 0 on this tick (comb.)
//  Macro       : CHIP_DAMAGE_EN - blocked hits cost 1 health while health > 1
//  Revision    : 1.0 - initial release
// ============================================================================
module stun_tracker
    import hit_resolver_pkg::*;
#(
    parameter int HEALTH_MAX       = 3,
    parameter int HITSTUN_FRAMES   = 20,
    parameter int BLOCKSTUN_FRAMES = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear_i,
    input  logic                tick_i,
    input  logic                frozen_i,
    input  logic [1:0]          stunmode_i,
    output logic [HEALTH_W-1:0] health_o,
    output logic                hitstun_o,
    output logic                blockstun_o,
    output logic                ko_o
);

    localparam logic [HEALTH_W-1:0] c_health_max = HEALTH_W'(HEALTH_MAX);
    localparam logic [TIMER_W-1:0]  c_hit_load   = TIMER_W'(HITSTUN_FRAMES);
    localparam logic [TIMER_W-1:0]  c_blk_load   = TIMER_W'(BLOCKSTUN_FRAMES);

    logic [1:0]          prev_q,   prev_d;
    logic [HEALTH_W-1:0] health_q, health_d;
    logic [TIMER_W-1:0]  hit_q,    hit_d;
    logic [TIMER_W-1:0]  blk_q,    blk_d;

    logic new_hit;
    logic new_block;

    // An attack spans several frames with the same code; only the first
    // frame of a run counts as an event.
    assign new_hit   = tick_i && !frozen_i &&
                       (stunmode_i == STUN_HIT)   && (prev_q != STUN_HIT);
    assign new_block = tick_i && !frozen_i &&
                       (stunmode_i == STUN_BLOCK) && (prev_q != STUN_BLOCK);

    always_comb begin
        prev_d   = prev_q;
        health_d = health_q;
        hit_d    = hit_q;
        blk_d    = blk_q;
        if (clear_i) begin
            prev_d   = STUN_NEUTRAL;
            health_d = c_health_max;
            hit_d    = '0;
            blk_d    = '0;
        end else if (tick_i) begin
            // prev keeps tracking even after game over
            prev_d = stunmode_i;
            if (new_hit) begin
                health_d = health_sat_dec(health_q);
                hit_d    = c_hit_load;
                blk_d    = '0;
            end else if (new_block) begin
                blk_d = c_blk_load;
`ifdef CHIP_DAMAGE_EN
                // Chip damage may never deliver the knockout
                if (health_q > HEALTH_W'(1)) begin
                    health_d = health_q - HEALTH_W'(1);
                end
`else
                // Blocked hits are free: health untouched
`endif
            end else begin
                hit_d = timer_sat_dec(hit_q);
                blk_d = timer_sat_dec(blk_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q   <= STUN_NEUTRAL;
            health_q <= c_health_max;
            hit_q    <= '0;
            blk_q    <= '0;
        end else begin
            prev_q   <= prev_d;
            health_q <= health_d;
            hit_q    <= hit_d;
            blk_q    <= blk_d;
        end
    end

    assign health_o    = health_q;
    assign hitstun_o   = (hit_q != '0);
    assign blockstun_o = (blk_q != '0);
    assign ko_o        = tick_i && !clear_i && !frozen_i && (health_d == '0);

endmodule : stun_tracker
`default_nettype wire

// File: rtl/hit_resolver.sv
`default_nettype none
// ============================================================================
//  Module      : hit_resolver
//  Description : Per-frame damage and stun bookkeeping for both players.
//                Two stun_tracker instances run in parallel; this level holds
//                the game-over/winner latch and the restart priority
//                (rst > round_restart > frame_tick).
//  Ports       : clk, rst                 - clock, sync active-high reset
//                frame_tick               - one pulse per game frame
//                round_restart            - reload health, clear everything
//                p1_stunmode, p2_stunmode - stunmode codes from hit detection
//                p1_health, p2_health     - current health
//                p1/p2_hitstun            - hitstun timer nonzero
//                p1/p2_blockstun          - blockstun timer nonzero
//                game_over                - latched once any health hits 0
//                winner                   - 01 P1, 10 P2, 11 draw
//  Macro       : CHIP_DAMAGE_EN - blocked hits cost 1 health while health > 1
//  Revision    : 1.0 - initial release
// ============================================================================
module hit_resolver
    import hit_resolver_pkg::*;
#(
    parameter int HEALTH_MAX       = 3,
    parameter int HITSTUN_FRAMES   = 20,
    parameter int BLOCKSTUN_FRAMES = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_tick,
    input  logic                round_restart,
    input  logic [1:0]          p1_stunmode,
    input  logic [1:0]          p2_stunmode,
    output logic [HEALTH_W-1:0] p1_health,
    output logic [HEALTH_W-1:0] p2_health,
    output logic                p1_hitstun,
    output logic                p1_blockstun,
    output logic                p2_hitstun,
    output logic                p2_blockstun,
    output logic                game_over,
    output logic [1:0]          winner
);

    logic       tick;
    logic       p1_ko;
    logic       p2_ko;
    logic       game_over_q, game_over_d;
    logic [1:0] winner_q,    winner_d;

    // A restart on a tick cycle swallows the tick entirely
    assign tick = frame_tick && !round_restart;

    stun_tracker #(
        .HEALTH_MAX       (HEALTH_MAX),
        .HITSTUN_FRAMES   (HITSTUN_FRAMES),
        .BLOCKSTUN_FRAMES (BLOCKSTUN_FRAMES)
    ) u_p1_tracker (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (round_restart),
        .tick_i      (tick),
        .frozen_i    (game_over_q),
        .stunmode_i  (p1_stunmode),
        .health_o    (p1_health),
        .hitstun_o   (p1_hitstun),
        .blockstun_o (p1_blockstun),
        .ko_o        (p1_ko)
    );

    stun_tracker #(
        .HEALTH_MAX       (HEALTH_MAX),
        .HITSTUN_FRAMES   (HITSTUN_FRAMES),
        .BLOCKSTUN_FRAMES (BLOCKSTUN_FRAMES)
    ) u_p2_tracker (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (round_restart),
        .tick_i      (tick),
        .frozen_i    (game_over_q),
        .stunmode_i  (p2_stunmode),
        .health_o    (p2_health),
        .hitstun_o   (p2_hitstun),
        .blockstun_o (p2_blockstun),
        .ko_o        (p2_ko)
    );

    always_comb begin
        game_over_d = game_over_q;
        winner_d    = winner_q;
        if (round_restart) begin
            game_over_d = 1'b0;
            winner_d    = WIN_NONE;
        end else if (!game_over_q && (p1_ko || p2_ko)) begin
            // ko flags are already qualified by the tick.
            // Winner bit 1 = P1 KO'd, bit 0 = P2 KO'd; both set gives a draw.
            game_over_d = 1'b1;
            winner_d    = {p1_ko, p2_ko};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            game_over_q <= 1'b0;
            winner_q    <= WIN_NONE;
        end else begin
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
        end
    end

    assign game_over = game_over_q;
    assign winner    = winner_q;

endmodule : hit_resolver
`default_nettype wire

// File: tb/tb_hit_resolver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hit_resolver
//  Description : Self-checking bench for hit_resolver with a frame-level
//                reference model (integer health/timers per player).
//  Macro       : CHIP_DAMAGE_EN - bench expectations follow the same macro
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hit_resolver;

    localparam int HM = 3;
    localparam int HF = 20;
    localparam int BF = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       round_restart = 1'b0;
    logic [1:0] p1_stunmode = 2'b00;
    logic [1:0] p2_stunmode = 2'b00;
    logic [2:0] p1_health;
    logic [2:0] p2_health;
    logic       p1_hitstun;
    logic       p1_blockstun;
    logic       p2_hitstun;
    logic       p2_blockstun;
    logic       game_over;
    logic [1:0] winner;

    always #5 clk = ~clk;

    hit_resolver #(
        .HEALTH_MAX       (HM),
        .HITSTUN_FRAMES   (HF),
        .BLOCKSTUN_FRAMES (BF)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_tick    (frame_tick),
        .round_restart (round_restart),
        .p1_stunmode   (p1_stunmode),
        .p2_stunmode   (p2_stunmode),
        .p1_health     (p1_health),
        .p2_health     (p2_health),
        .p1_hitstun    (p1_hitstun),
        .p1_blockstun  (p1_blockstun),
        .p2_hitstun    (p2_hitstun),
        .p2_blockstun  (p2_blockstun),
        .game_over     (game_over),
        .winner        (winner)
    );

    // Reference model: frames of stun remaining, health points, last code
    int m_h[2];
    int m_ht[2];
    int m_bt[2];
    int m_prev[2];
    int m_go;
    int m_win;

    int n_assert = 0;
    int n_fail   = 0;

    function automatic void model_clear();
        for (int p = 0; p < 2; p++) begin
            m_h[p] = HM; m_ht[p] = 0; m_bt[p] = 0; m_prev[p] = 0;
        end
        m_go = 0; m_win = 0;
    endfunction

    function automatic void model_tick(input int a, input int b);
        bit ko[2];
        for (int p = 0; p < 2; p++) begin
            int  cur;
            bit  hit;
            bit  blk;
            cur   = (p == 0) ? a : b;
            hit   = (m_go == 0) && (cur == 1) && (m_prev[p] != 1);
            blk   = (m_go == 0) && (cur == 2) && (m_prev[p] != 2);
            ko[p] = 1'b0;
            if (hit) begin
                if (m_h[p] > 0) m_h[p] = m_h[p] - 1;
                ko[p]   = (m_h[p] == 0);
                m_ht[p] = HF;
                m_bt[p] = 0;
            end else if (blk) begin
                m_bt[p] = BF;
`ifdef CHIP_DAMAGE_EN
                if (m_h[p] > 1) m_h[p] = m_h[p] - 1;
`endif
            end else begin
                if (m_ht[p] > 0) m_ht[p] = m_ht[p] - 1;
                if (m_bt[p] > 0) m_bt[p] = m_bt[p] - 1;
            end
            m_prev[p] = cur;
        end
        if (m_go == 0 && (ko[0] || ko[1])) begin
            m_go  = 1;
            m_win = (ko[1] ? 1 : 0) + (ko[0] ? 2 : 0);
        end
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input int exp);
        n_assert++;
        assert (obs === 8'(exp)) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".p1_health"},    8'(p1_health),    m_h[0]);
        chk({tag, ".p2_health"},    8'(p2_health),    m_h[1]);
        chk({tag, ".p1_hitstun"},   8'(p1_hitstun),   int'(m_ht[0] != 0));
        chk({tag, ".p1_blockstun"}, 8'(p1_blockstun), int'(m_bt[0] != 0));
        chk({tag, ".p2_hitstun"},   8'(p2_hitstun),   int'(m_ht[1] != 0));
        chk({tag, ".p2_blockstun"}, 8'(p2_blockstun), int'(m_bt[1] != 0));
        chk({tag, ".game_over"},    8'(game_over),    m_go);
        chk({tag, ".winner"},       8'(winner),       m_win);
    endtask

    // One clock cycle: drive at negedge, sample 1 time unit after posedge
    task automatic step(input string tag, input bit r, input bit rr,
                        input bit t, input int a, input int b);
        @(negedge clk);
        rst           = r;
        round_restart = rr;
        frame_tick    = t;
        p1_stunmode   = 2'(a);
        p2_stunmode   = 2'(b);
        @(posedge clk);
        #1;
        if (r || rr)  model_clear();
        else if (t)   model_tick(a, b);
        check_all(tag);
    endtask

    task automatic tick(input string tag, input int a, input int b);
        step(tag, 1'b0, 1'b0, 1'b1, a, b);
    endtask

    initial begin
        int cnt;
        model_clear();

        // Reset state
        step("reset0", 1'b1, 1'b0, 1'b0, 0, 0);
        step("reset1", 1'b1, 1'b0, 1'b1, 1, 2);
        step("idle",   1'b0, 1'b0, 1'b0, 1, 1);

        // P2 holds 01 for four ticks: one hit, 20 ticks of hitstun
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick("p2hold", 0, 1);
            cnt += int'(p2_hitstun);
        end
        chk("p2_hold_health", 8'(p2_health), HM - 1);
        for (int i = 0; i < 26; i++) begin
            tick("p2decay", 0, 0);
            cnt += int'(p2_hitstun);
        end
        chk("p2_hitstun_len", 8'(cnt), HF);

        // P1 blocks for two ticks: 12 ticks of blockstun
        cnt = 0;
        for (int i = 0; i < 2; i++) begin
            tick("p1blk", 2, 0);
            cnt += int'(p1_blockstun);
        end
`ifdef CHIP_DAMAGE_EN
        chk("p1_block_health", 8'(p1_health), HM - 1);
`else
        chk("p1_block_health", 8'(p1_health), HM);
`endif
        for (int i = 0; i < 16; i++) begin
            tick("p1blkdecay", 0, 0);
            cnt += int'(p1_blockstun);
        end
        chk("p1_blockstun_len", 8'(cnt), BF);

`ifdef CHIP_DAMAGE_EN
        // Chip damage cannot take the last point
        step("chip_rr", 1'b0, 1'b1, 1'b0, 0, 0);
        tick("chip", 1, 0); tick("chip", 0, 0);
        tick("chip", 1, 0); tick("chip", 0, 0);
        tick("chip", 2, 0);
        chk("chip_health1", 8'(p1_health), 1);
`endif

        // P2 knocked out by three separated hits; P1 then frozen
        step("ko_rr", 1'b0, 1'b1, 1'b0, 0, 0);
        tick("ko", 0, 1); tick("ko", 0, 0);
        tick("ko", 0, 1); tick("ko", 0, 0);
        tick("ko", 0, 1);
        chk("ko_game_over", 8'(game_over), 1);
        chk("ko_winner",    8'(winner),    1);
        chk("ko_p2_health", 8'(p2_health), 0);
        tick("ko_frozen", 1, 0);
        chk("ko_p1_frozen", 8'(p1_health), HM);

        // Double knockout on the same tick
        step("draw_rr", 1'b0, 1'b1, 1'b0, 0, 0);
        tick("draw", 1, 1); tick("draw", 0, 0);
        tick("draw", 1, 1); tick("draw", 0, 0);
        tick("draw", 1, 1);
        chk("draw_winner", 8'(winner), 3);
        chk("draw_p1_h",   8'(p1_health), 0);

        // Combo: second hit 5 ticks later reloads hitstun and deals damage
        step("combo_rr", 1'b0, 1'b1, 1'b0, 0, 0);
        tick("combo", 1, 0);
        for (int i = 0; i < 4; i++) tick("combo", 0, 0);
        tick("combo", 1, 0);
        chk("combo_health", 8'(p1_health), HM - 2);
        cnt = int'(p1_hitstun);
        for (int i = 0; i < 24; i++) begin
            tick("combo_decay", 0, 0);
            cnt += int'(p1_hitstun);
        end
        chk("combo_hitstun_len", 8'(cnt), HF);

        // round_restart, then rst, colliding with a tick that carries a hit
        tick("rr_pre", 0, 1); tick("rr_pre", 0, 0);
        step("rr_collide", 1'b0, 1'b1, 1'b1, 0, 1);
        chk("rr_p2_health", 8'(p2_health), HM);
        chk("rr_p2_hitstun", 8'(p2_hitstun), 0);
        tick("rst_pre", 0, 1); tick("rst_pre", 0, 0);
        step("rst_collide", 1'b1, 1'b0, 1'b1, 0, 1);
        chk("rst_p2_health", 8'(p2_health), HM);
        chk("rst_game_over", 8'(game_over), 0);
        tick("post_rst_hit", 0, 1);
        chk("post_rst_health", 8'(p2_health), HM - 1);

        // Randomized play
        for (int i = 0; i < 1500; i++) begin
            bit r, rr, t;
            r  = ($urandom_range(0, 199) == 0);
            rr = ($urandom_range(0, 59) == 0);
            t  = ($urandom_range(0, 2) != 0);
            step("rand", r, rr, t, int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)));
        end

        @(negedge clk);
        frame_tick = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule : tb_hit_resolver
`default_nettype wire
